dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port,
// synchronous-read data memory of DEPTH 32-bit words.
//
// Ports
//   clk, rst              : clock and synchronous active-high reset
//   pN_valid/pN_ready     : request handshake. p0 is the core load/store port
//                           and p1 is the loader/debug port. ready is
//                           combinational.
//   pN_we/addr/wdata/wstrb: request fields (byte address, byte strobes)
//   pN_rsp_valid/rdata/err: one-cycle response, exactly 1 cycle after accept
//   mem_en/we/addr/wdata/wstrb : memory access (word address, AW bits)
//   mem_rdata             : memory read data, valid the cycle after a read
//   perf_grant0/1, perf_conflict : saturating counters, present only when
//                           DMEM_ARB_PERF_EN is defined
module dmem_arbiter #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [31:0]   p0_addr,
  input  logic [31:0]   p0_wdata,
  input  logic [3:0]    p0_wstrb,
  output logic          p0_rsp_valid,
  output logic [31:0]   p0_rsp_rdata,
  output logic          p0_rsp_err,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [31:0]   p1_addr,
  input  logic [31:0]   p1_wdata,
  input  logic [3:0]    p1_wstrb,
  output logic          p1_rsp_valid,
  output logic [31:0]   p1_rsp_rdata,
  output logic          p1_rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_grant0,
  output logic [31:0]   perf_grant1,
  output logic [31:0]   perf_conflict
`endif
);

  typedef enum logic {PRIO_P0 = 1'b0, PRIO_P1 = 1'b1} prio_t;

  prio_t       prio, prio_nxt;
  logic        gnt0, gnt1;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        acc_ok;

  // Response tracker: the single access in flight from last cycle.
  logic        trk_busy, trk_port, trk_read, trk_err;
  logic        rsp_live;
  logic [31:0] rsp_data;

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    prio_nxt = prio;
    if (!rst) begin
      if (p0_valid && (!p1_valid || prio == PRIO_P0)) gnt0 = 1'b1;
      else if (p1_valid)                              gnt1 = 1'b1;
    end
    if (gnt0)      prio_nxt = PRIO_P1;
    else if (gnt1) prio_nxt = PRIO_P0;

    sel_we    = gnt1 ? p1_we    : p0_we;
    sel_addr  = gnt1 ? p1_addr  : p0_addr;
    sel_wdata = gnt1 ? p1_wdata : p0_wdata;
    sel_wstrb = gnt1 ? p1_wstrb : p0_wstrb;
    acc_ok    = (sel_addr[1:0] == 2'b00) && (sel_addr[31:2] < 30'(DEPTH));

    // Error grants are still accepted but never reach the memory.
    mem_en    = (gnt0 || gnt1) && acc_ok;
    mem_we    = mem_en && sel_we;
    mem_addr  = mem_en ? sel_addr[AW+1:2] : '0;
    mem_wdata = mem_en ? sel_wdata : '0;
    mem_wstrb = mem_en ? sel_wstrb : '0;

    p0_ready  = gnt0;
    p1_ready  = gnt1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= PRIO_P0;
      trk_busy <= 1'b0;
      trk_port <= 1'b0;
      trk_read <= 1'b0;
      trk_err  <= 1'b0;
    end else begin
      prio     <= prio_nxt;
      trk_busy <= gnt0 || gnt1;
      trk_port <= gnt1;
      trk_read <= !sel_we;
      trk_err  <= !acc_ok;
    end
  end

  // Gating with rst drops a response whose acceptance preceded the reset.
  always_comb begin
    rsp_live     = trk_busy && !rst;
    rsp_data     = (trk_read && !trk_err) ? mem_rdata : '0;
    p0_rsp_valid = rsp_live && !trk_port;
    p1_rsp_valid = rsp_live && trk_port;
    p0_rsp_err   = p0_rsp_valid && trk_err;
    p1_rsp_err   = p1_rsp_valid && trk_err;
    p0_rsp_rdata = p0_rsp_valid ? rsp_data : '0;
    p1_rsp_rdata = p1_rsp_valid ? rsp_data : '0;
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (gnt0 && perf_grant0 != '1) perf_grant0 <= perf_grant0 + 32'd1;
      if (gnt1 && perf_grant1 != '1) perf_grant1 <= perf_grant1 + 32'd1;
      if (p0_valid && p1_valid && perf_conflict != '1)
        perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int VW    = 108 + AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_valid, p0_we, p1_valid, p1_we;
  logic [31:0]   p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]    p0_wstrb, p1_wstrb;
  logic          p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
  logic [31:0]   p0_rsp_rdata, p1_rsp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   perf_grant0, perf_grant1, perf_conflict;
  int unsigned   ref_pg0, ref_pg1, ref_pc;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
  );

  // Environment: synchronous-read memory driven by the DUT, cleared by rst.
  logic [31:0] tmem [DEPTH];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tmem[i] <= '0;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) tmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= tmem[mem_addr];
      end
    end
  end

  // Reference model: transaction-level arbiter + word array.
  int          ref_prio = 0;
  bit          pend_v = 0;
  int          pend_port = 0;
  bit          pend_err = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] ref_mem [DEPTH];
  bit          g_v, g_ok, g_we;
  int          g_port;
  logic [31:0] g_a, g_wd;
  logic [3:0]  g_ws;
  logic [VW-1:0] exp_vec;

  function automatic logic [VW-1:0] obs_vec();
    return {p0_ready, p1_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
            p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata, p1_rsp_rdata, p0_rsp_err, p1_rsp_err};
  endfunction

  function automatic void model_eval();
    logic rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;
    rv0 = 0; rv1 = 0; er0 = 0; er1 = 0; rd0 = '0; rd1 = '0;
    if (!rst && pend_v) begin
      if (pend_port == 0) begin rv0 = 1; rd0 = pend_data; er0 = pend_err; end
      else                begin rv1 = 1; rd1 = pend_data; er1 = pend_err; end
    end
    g_v = 0; g_port = 0;
    if (!rst) begin
      if (p0_valid && p1_valid) begin g_v = 1; g_port = ref_prio; end
      else if (p0_valid)        begin g_v = 1; g_port = 0; end
      else if (p1_valid)        begin g_v = 1; g_port = 1; end
    end
    g_we = (g_port == 1) ? p1_we    : p0_we;
    g_a  = (g_port == 1) ? p1_addr  : p0_addr;
    g_wd = (g_port == 1) ? p1_wdata : p0_wdata;
    g_ws = (g_port == 1) ? p1_wstrb : p0_wstrb;
    g_ok = g_v && (g_a % 4 == 0) && ((g_a / 4) < DEPTH);
    exp_vec = {g_v && g_port == 0, g_v && g_port == 1, g_ok, g_ok && g_we,
               g_ok ? g_a[AW+1:2] : {AW{1'b0}}, g_ok ? g_wd : 32'd0, g_ok ? g_ws : 4'd0,
               rv0, rv1, rd0, rd1, er0, er1};
  endfunction

  function automatic void model_commit();
    if (rst) begin
      pend_v = 0; ref_prio = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`ifdef DMEM_ARB_PERF_EN
      ref_pg0 = 0; ref_pg1 = 0; ref_pc = 0;
`endif
    end else begin
`ifdef DMEM_ARB_PERF_EN
      if (g_v && g_port == 0) ref_pg0++;
      if (g_v && g_port == 1) ref_pg1++;
      if (p0_valid && p1_valid) ref_pc++;
`endif
      pend_v = g_v;
      if (g_v) begin
        pend_port = g_port;
        pend_err  = !g_ok;
        pend_data = (g_ok && !g_we) ? ref_mem[g_a / 4] : 32'd0;
        if (g_ok && g_we)
          for (int b = 0; b < 4; b++)
            if (g_ws[b]) ref_mem[g_a / 4][8*b +: 8] = g_wd[8*b +: 8];
        ref_prio = 1 - g_port;
      end
    end
  endfunction

  task automatic drive(input logic v0, we0, input logic [31:0] a0, wd0, input logic [3:0] ws0,
                       input logic v1, we1, input logic [31:0] a1, wd1, input logic [3:0] ws1);
    p0_valid = v0; p0_we = we0; p0_addr = a0; p0_wdata = wd0; p0_wstrb = ws0;
    p1_valid = v1; p1_we = we1; p1_addr = a1; p1_wdata = wd1; p1_wstrb = ws1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(1, 1, 32'h0, 32'hDEAD_BEEF, 4'hF, 1, 0, 32'h4, 32'h0, 4'h0);
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++; $display("FAIL reset[%0d]: got %h want %h", c, obs_vec(), exp_vec);
      end
      checks++;
      if (p0_ready !== 1'b0) begin
        failures++; $display("FAIL reset_ready: got %b want 0", p0_ready);
      end
      tick();
    end
    rst = 0;
    idle();
  endtask

  task automatic test_write_read();
    for (int c = 0; c < 3; c++) begin
      if (c == 0)      drive(1, 1, 32'h0, 32'd15, 4'hF, 0, 0, 0, 0, 0);
      else if (c == 1) drive(1, 0, 32'h0, 32'd0, 4'h0, 0, 0, 0, 0, 0);
      else             idle();
      settle();
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++; $display("FAIL write_read[%0d]: got %h want %h", c, obs_vec(), exp_vec);
      end
      if (c == 2) begin
        checks++;
        if (p0_rsp_rdata !== 32'd15 || p0_rsp_valid !== 1'b1 || p1_rsp_valid !== 1'b0) begin
          failures++; $display("FAIL read_back: got v=%b d=%0d want v=1 d=15", p0_rsp_valid, p0_rsp_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    rst = 1; idle(); settle(); tick(); rst = 0;
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drive(1, 0, 32'h10, 0, 0, 1, 0, 32'h20, 0, 0);
      else idle();
      settle();
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++; $display("FAIL conflict[%0d]: got %h want %h", c, obs_vec(), exp_vec);
      end
      if (c < 4) begin
        checks++;
        if (p0_ready !== (c % 2 == 0) || p1_ready !== (c % 2 == 1)) begin
          failures++; $display("FAIL conflict_alt[%0d]: got %b%b want %b%b", c, p0_ready, p1_ready, c % 2 == 0, c % 2 == 1);
        end
      end
`ifdef DMEM_ARB_PERF_EN
      if (c == 4) begin
        checks++;
        if (perf_conflict !== 32'd4) begin
          failures++; $display("FAIL perf_conflict: got %0d want 4", perf_conflict);
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_errors();
    for (int c = 0; c < 3; c++) begin
      if (c == 0)      drive(0, 0, 0, 0, 0, 1, 0, 32'h2, 0, 0);
      else if (c == 1) drive(0, 0, 0, 0, 0, 1, 0, 32'h400, 0, 0);
      else             idle();
      settle();
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++; $display("FAIL errors[%0d]: got %h want %h", c, obs_vec(), exp_vec);
      end
      checks++;
      if (mem_en !== 1'b0 || (c > 0 && (p1_rsp_err !== 1'b1 || p1_rsp_rdata !== 32'd0))) begin
        failures++; $display("FAIL errors_flag[%0d]: got en=%b err=%b want en=0 err=1", c, mem_en, p1_rsp_err);
      end
      tick();
    end
  endtask

  task automatic test_reset_cancel();
    for (int c = 0; c < 4; c++) begin
      rst = (c == 1);
      if (c == 0)      drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      else if (c == 2) drive(1, 0, 32'h8, 0, 0, 1, 0, 32'hC, 0, 0);
      else             idle();
      settle();
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++; $display("FAIL reset_cancel[%0d]: got %h want %h", c, obs_vec(), exp_vec);
      end
      if (c == 1) begin
        checks++;
        if (p0_rsp_valid !== 1'b0) begin
          failures++; $display("FAIL cancel_rsp: got %b want 0", p0_rsp_valid);
        end
      end
      if (c == 2) begin
        checks++;
        if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
          failures++; $display("FAIL cancel_prio: got %b%b want 10", p0_ready, p1_ready);
        end
      end
      tick();
    end
    rst = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'd10; vals[1] = 32'd20; vals[2] = 32'd30;
    for (int c = 0; c < 7; c++) begin
      if (c < 3)      drive(1, 1, 32'(4 * c), vals[c], 4'hF, 0, 0, 0, 0, 0);
      else if (c < 6) drive(1, 0, 32'(4 * (c - 3)), 0, 0, 0, 0, 0, 0, 0);
      else            idle();
      settle();
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++; $display("FAIL b2b[%0d]: got %h want %h", c, obs_vec(), exp_vec);
      end
      if (c >= 4) begin
        checks++;
        if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== vals[c - 4]) begin
          failures++; $display("FAIL b2b_data[%0d]: got v=%b d=%0d want v=1 d=%0d", c, p0_rsp_valid, p0_rsp_rdata, vals[c - 4]);
        end
      end
      tick();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned m;
    m = $urandom_range(0, 9);
    if (m == 0) return 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
    if (m == 1) return 32'(4 * DEPTH + 4 * $urandom_range(0, 1000));
    return 32'(4 * $urandom_range(0, 15));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom));
      settle();
      checks++;
      if (obs_vec() !== exp_vec) begin
        failures++; $display("FAIL random[%0d]: got %h want %h", c, obs_vec(), exp_vec);
      end
      tick();
    end
    rst = 0;
    idle();
    settle();
    checks++;
    if (obs_vec() !== exp_vec) begin
      failures++; $display("FAIL random_drain: got %h want %h", obs_vec(), exp_vec);
    end
`ifdef DMEM_ARB_PERF_EN
    checks++;
    if (perf_grant0 !== ref_pg0 || perf_grant1 !== ref_pg1 || perf_conflict !== ref_pc) begin
      failures++; $display("FAIL perf_random: got %0d/%0d/%0d want %0d/%0d/%0d",
        perf_grant0, perf_grant1, perf_conflict, ref_pg0, ref_pg1, ref_pc);
    end
`endif
    tick();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_write_read();
    test_conflict();
    test_errors();
    test_reset_cancel();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
